gpmc_fifo_regs: RTL and testbench

Memory-mapped FIFO window sitting directly downstream of `gpmc_sram`'s decoded bus port. It turns single-word GPMC host accesses into two streaming FIFOs: a host-to-fabric TX stream and a fabric-to-host RX stream. It also provides a status/control register pair, so AM335x software can move data to and from FPGA logic without a dedicated DMA path.

---
 rtl/gpmc_fifo_regs.sv | 200 ++++++++++++++++++++
 tb/tb_gpmc_fifo_regs.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpmc_fifo_regs.sv
// gpmc_fifo_regs
//   Memory-mapped FIFO window behind the GPMC decoded bus port. Host writes
//   to register 0 feed a TX stream toward the fabric; fabric words pushed on
//   the RX stream are read back by the host through register 1. STATUS
//   (reg 2) and CONTROL (reg 3) expose FIFO state and sticky error flags, and
//   reg 7 returns a constant ID.
//
// Ports
//   GPMC_CLK   sole clock, rising edge
//   RST        asynchronous active-high reset
//   BUS_ADDR   word register index
//   BUS_WDATA  write data
//   BUS_BE     byte enables (bit0 = [7:0])
//   BUS_WE     one-cycle write strobe
//   BUS_RE     one-cycle read strobe
//   BUS_RDATA  registered read data, valid the cycle after BUS_RE
//   TX_DATA    TX FIFO head word (show-ahead, 0 when empty)
//   TX_VALID   TX FIFO not empty
//   TX_READY   fabric accepts TX_DATA
//   RX_DATA    fabric word toward the host
//   RX_VALID   RX_DATA valid
//   RX_READY   RX FIFO can accept a word (0 while RST is high)

module gpmc_fifo_regs #(
    parameter int          DEPTH_LOG2 = 4,
    parameter logic [15:0] ID         = 16'hF1F0
) (
    input  logic        GPMC_CLK,
    input  logic        RST,
    input  logic [2:0]  BUS_ADDR,
    input  logic [15:0] BUS_WDATA,
    input  logic [1:0]  BUS_BE,
    input  logic        BUS_WE,
    input  logic        BUS_RE,
    output logic [15:0] BUS_RDATA,
    output logic [15:0] TX_DATA,
    output logic        TX_VALID,
    input  logic        TX_READY,
    input  logic [15:0] RX_DATA,
    input  logic        RX_VALID,
    output logic        RX_READY
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CW    = DEPTH_LOG2 + 1;

    localparam logic [CW-1:0]         CNT_FULL = CW'(DEPTH);
    localparam logic [CW-1:0]         CNT_ONE  = CW'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

    localparam logic [2:0] REG_TX     = 3'd0;
    localparam logic [2:0] REG_RX     = 3'd1;
    localparam logic [2:0] REG_STATUS = 3'd2;
    localparam logic [2:0] REG_CTRL   = 3'd3;
    localparam logic [2:0] REG_ID     = 3'd7;

    // Count update; a flush overrides any same-cycle push or pop.
    function automatic logic [CW-1:0] next_count(input logic [CW-1:0] cnt,
                                                 input logic push,
                                                 input logic pop,
                                                 input logic flush);
        logic [CW-1:0] res;
        res = cnt;
        if (flush) begin
            res = '0;
        end else if (push && !pop) begin
            res = cnt + CNT_ONE;
        end else if (pop && !push) begin
            res = cnt - CNT_ONE;
        end
        return res;
    endfunction

    // Pointer update; wraps naturally at DEPTH.
    function automatic logic [DEPTH_LOG2-1:0] next_ptr(input logic [DEPTH_LOG2-1:0] ptr,
                                                       input logic adv,
                                                       input logic flush);
        logic [DEPTH_LOG2-1:0] res;
        res = ptr;
        if (flush) begin
            res = '0;
        end else if (adv) begin
            res = ptr + PTR_ONE;
        end
        return res;
    endfunction

    logic [15:0]           tx_mem_q [DEPTH];
    logic [15:0]           rx_mem_q [DEPTH];

    logic [DEPTH_LOG2-1:0] tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
    logic [DEPTH_LOG2-1:0] rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
    logic [CW-1:0]         tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
    logic                  txovf_q, txovf_d, rxunf_q, rxunf_d, pwerr_q, pwerr_d;
    logic [15:0]           bus_rdata_q, bus_rdata_d;

    logic tx_full, tx_empty, rx_full, rx_empty;
    logic tx_wr_acc, rx_rd_acc, ctrl_wr;
    logic flag_clr, tx_flush, rx_flush;
    logic tx_push, tx_pop, rx_push, rx_pop;
    logic txovf_evt, rxunf_evt, pwerr_evt;
    logic [15:0] status_word, ctrl_word, rd_mux;

    assign tx_full  = (tx_cnt_q == CNT_FULL);
    assign tx_empty = (tx_cnt_q == '0);
    assign rx_full  = (rx_cnt_q == CNT_FULL);
    assign rx_empty = (rx_cnt_q == '0);

    assign TX_VALID  = !tx_empty;
    assign TX_DATA   = tx_empty ? 16'h0000 : tx_mem_q[tx_rd_q];
    // Held low during reset without waiting for a clock.
    assign RX_READY  = !RST && !rx_full;
    assign BUS_RDATA = bus_rdata_q;

    always_comb begin
        tx_wr_acc = BUS_WE && (BUS_ADDR == REG_TX);
        rx_rd_acc = BUS_RE && (BUS_ADDR == REG_RX);
        ctrl_wr   = BUS_WE && (BUS_ADDR == REG_CTRL);

        flag_clr  = ctrl_wr && BUS_WDATA[0];
        tx_flush  = ctrl_wr && BUS_WDATA[1];
        rx_flush  = ctrl_wr && BUS_WDATA[2];

        // A write to a full TX FIFO is dropped even when the fabric pops in
        // the same cycle, so fullness is judged on the pre-edge count.
        txovf_evt = tx_wr_acc && tx_full;
        pwerr_evt = tx_wr_acc && (BUS_BE != 2'b11);
        rxunf_evt = rx_rd_acc && rx_empty;

        tx_push   = tx_wr_acc && (BUS_BE == 2'b11) && !tx_full && !tx_flush;
        tx_pop    = TX_VALID && TX_READY && !tx_flush;
        rx_push   = RX_VALID && RX_READY && !rx_flush;
        rx_pop    = rx_rd_acc && !rx_empty && !rx_flush;

        tx_wr_d   = next_ptr(tx_wr_q, tx_push, tx_flush);
        tx_rd_d   = next_ptr(tx_rd_q, tx_pop, tx_flush);
        rx_wr_d   = next_ptr(rx_wr_q, rx_push, rx_flush);
        rx_rd_d   = next_ptr(rx_rd_q, rx_pop, rx_flush);
        tx_cnt_d  = next_count(tx_cnt_q, tx_push, tx_pop, tx_flush);
        rx_cnt_d  = next_count(rx_cnt_q, rx_push, rx_pop, rx_flush);

        // A new event outranks a same-cycle clear.
        txovf_d   = (txovf_q && !flag_clr) || txovf_evt;
        rxunf_d   = (rxunf_q && !flag_clr) || rxunf_evt;
        pwerr_d   = (pwerr_q && !flag_clr) || pwerr_evt;

        // Read words reflect pre-edge state.
        status_word = {8'(rx_cnt_q), 1'b0, pwerr_q, rxunf_q, txovf_q,
                       rx_empty, rx_full, tx_empty, tx_full};
        ctrl_word   = {8'h00, 8'(tx_cnt_q)};

        rd_mux = 16'h0000;
        case (BUS_ADDR)
            REG_RX:     rd_mux = rx_empty ? 16'h0000 : rx_mem_q[rx_rd_q];
            REG_STATUS: rd_mux = status_word;
            REG_CTRL:   rd_mux = ctrl_word;
            REG_ID:     rd_mux = ID;
            default:    rd_mux = 16'h0000;
        endcase

        bus_rdata_d = BUS_RE ? rd_mux : bus_rdata_q;
    end

    always_ff @(posedge GPMC_CLK or posedge RST) begin
        if (RST) begin
            tx_wr_q     <= '0;
            tx_rd_q     <= '0;
            rx_wr_q     <= '0;
            rx_rd_q     <= '0;
            tx_cnt_q    <= '0;
            rx_cnt_q    <= '0;
            txovf_q     <= 1'b0;
            rxunf_q     <= 1'b0;
            pwerr_q     <= 1'b0;
            bus_rdata_q <= 16'h0000;
        end else begin
            tx_wr_q     <= tx_wr_d;
            tx_rd_q     <= tx_rd_d;
            rx_wr_q     <= rx_wr_d;
            rx_rd_q     <= rx_rd_d;
            tx_cnt_q    <= tx_cnt_d;
            rx_cnt_q    <= rx_cnt_d;
            txovf_q     <= txovf_d;
            rxunf_q     <= rxunf_d;
            pwerr_q     <= pwerr_d;
            bus_rdata_q <= bus_rdata_d;
        end
    end

    // Storage carries no reset; visibility is governed by the counts.
    always_ff @(posedge GPMC_CLK) begin
        if (tx_push) begin
            tx_mem_q[tx_wr_q] <= BUS_WDATA;
        end
        if (rx_push) begin
            rx_mem_q[rx_wr_q] <= RX_DATA;
        end
    end

endmodule

// File: tb/tb_gpmc_fifo_regs.sv
// Testbench for gpmc_fifo_regs: directed scenarios on a default-depth
// instance and a DEPTH_LOG2=2 instance, then a randomized run of the default
// instance against a queue-based reference model.

module tb_gpmc_fifo_regs;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    // Default-depth instance
    logic [2:0]  bus_addr = '0;
    logic [15:0] bus_wdata = '0;
    logic [1:0]  bus_be = '0;
    logic        bus_we = 1'b0;
    logic        bus_re = 1'b0;
    logic [15:0] bus_rdata;
    logic [15:0] tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic [15:0] rx_data = '0;
    logic        rx_valid = 1'b0;
    logic        rx_ready;

    // Small instance (4-word FIFOs)
    logic [2:0]  s_addr = '0;
    logic [15:0] s_wdata = '0;
    logic [1:0]  s_be = '0;
    logic        s_we = 1'b0;
    logic        s_re = 1'b0;
    logic [15:0] s_rdata;
    logic [15:0] s_tx_data;
    logic        s_tx_valid;
    logic        s_tx_ready = 1'b0;
    logic [15:0] s_rx_data = '0;
    logic        s_rx_valid = 1'b0;
    logic        s_rx_ready;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    gpmc_fifo_regs dut (
        .GPMC_CLK (clk),
        .RST      (rst),
        .BUS_ADDR (bus_addr),
        .BUS_WDATA(bus_wdata),
        .BUS_BE   (bus_be),
        .BUS_WE   (bus_we),
        .BUS_RE   (bus_re),
        .BUS_RDATA(bus_rdata),
        .TX_DATA  (tx_data),
        .TX_VALID (tx_valid),
        .TX_READY (tx_ready),
        .RX_DATA  (rx_data),
        .RX_VALID (rx_valid),
        .RX_READY (rx_ready)
    );

    gpmc_fifo_regs #(.DEPTH_LOG2(2), .ID(16'hF1F0)) dut_s (
        .GPMC_CLK (clk),
        .RST      (rst),
        .BUS_ADDR (s_addr),
        .BUS_WDATA(s_wdata),
        .BUS_BE   (s_be),
        .BUS_WE   (s_we),
        .BUS_RE   (s_re),
        .BUS_RDATA(s_rdata),
        .TX_DATA  (s_tx_data),
        .TX_VALID (s_tx_valid),
        .TX_READY (s_tx_ready),
        .RX_DATA  (s_rx_data),
        .RX_VALID (s_rx_valid),
        .RX_READY (s_rx_ready)
    );

    // Advance one clock; returns 1 time unit after the rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [15:0] d, input logic [1:0] be);
        bus_addr = a; bus_wdata = d; bus_be = be; bus_we = 1'b1;
        cyc();
        bus_we = 1'b0;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [15:0] r);
        bus_addr = a; bus_re = 1'b1;
        cyc();
        bus_re = 1'b0;
        r = bus_rdata;
    endtask

    task automatic s_read(input logic [2:0] a, output logic [15:0] r);
        s_addr = a; s_re = 1'b1;
        cyc();
        s_re = 1'b0;
        r = s_rdata;
    endtask

    task automatic test_reset();
        logic [15:0] r;
        rst = 1'b1;
        cyc(); cyc();
        checks++; if (bus_rdata !== 16'h0000) begin errors++; $display("FAIL reset_rdata got=%h exp=0000", bus_rdata); end
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid got=%b exp=0", tx_valid); end
        checks++; if (tx_data !== 16'h0000) begin errors++; $display("FAIL reset_tx_data got=%h exp=0000", tx_data); end
        checks++; if (rx_ready !== 1'b0) begin errors++; $display("FAIL reset_rx_ready got=%b exp=0", rx_ready); end
        rst = 1'b0;
        #1;
        checks++; if (rx_ready !== 1'b1) begin errors++; $display("FAIL release_rx_ready got=%b exp=1", rx_ready); end
        bus_read(3'd7, r);
        checks++; if (r !== 16'hF1F0) begin errors++; $display("FAIL id_read got=%h exp=F1F0", r); end
        bus_read(3'd2, r);
        checks++; if (r !== 16'h000A) begin errors++; $display("FAIL reset_status got=%h exp=000A", r); end
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL idle_tx_valid got=%b exp=0", tx_valid); end
        bus_read(3'd5, r);
        checks++; if (r !== 16'h0000) begin errors++; $display("FAIL reg5_read got=%h exp=0000", r); end
    endtask

    task automatic test_tx_fill();
        logic [15:0] r;
        tx_ready = 1'b0;
        for (int i = 0; i < 16; i++) bus_write(3'd0, 16'h1000 + 16'(i), 2'b11);
        bus_read(3'd2, r);
        checks++; if (r !== 16'h0009) begin errors++; $display("FAIL tx_full_status got=%h exp=0009", r); end
        bus_read(3'd3, r);
        checks++; if (r !== 16'h0010) begin errors++; $display("FAIL tx_count_full got=%h exp=0010", r); end
        bus_read(3'd0, r);
        checks++; if (r !== 16'h0000) begin errors++; $display("FAIL reg0_read got=%h exp=0000", r); end
        bus_write(3'd0, 16'h1010, 2'b11);
        bus_read(3'd2, r);
        checks++; if (r !== 16'h0019) begin errors++; $display("FAIL txovf_status got=%h exp=0019", r); end
        // Write while full with a same-cycle pop: still dropped.
        tx_ready = 1'b1;
        bus_addr = 3'd0; bus_wdata = 16'h1011; bus_be = 2'b11; bus_we = 1'b1;
        checks++; if (tx_data !== 16'h1000) begin errors++; $display("FAIL tx_head0 got=%h exp=1000", tx_data); end
        cyc();
        bus_we = 1'b0;
        for (int i = 1; i < 16; i++) begin
            checks++;
            if (tx_valid !== 1'b1 || tx_data !== 16'h1000 + 16'(i)) begin
                errors++; $display("FAIL tx_drain[%0d] got=%h/%b exp=%h/1", i, tx_data, tx_valid, 16'h1000 + 16'(i));
            end
            cyc();
        end
        checks++; if (tx_valid !== 1'b0 || tx_data !== 16'h0000) begin errors++; $display("FAIL tx_drained got=%h/%b exp=0000/0", tx_data, tx_valid); end
        tx_ready = 1'b0;
        bus_write(3'd3, 16'h0001, 2'b00);
    endtask

    task automatic test_partial_write();
        logic [15:0] r;
        bus_write(3'd0, 16'h5555, 2'b01);
        bus_read(3'd3, r);
        checks++; if (r !== 16'h0000) begin errors++; $display("FAIL partial_tx_count got=%h exp=0000", r); end
        bus_read(3'd2, r);
        checks++; if (r !== 16'h004A) begin errors++; $display("FAIL pwerr_status got=%h exp=004A", r); end
        bus_write(3'd3, 16'h0001, 2'b11);
        bus_read(3'd2, r);
        checks++; if (r !== 16'h000A) begin errors++; $display("FAIL flag_clear_status got=%h exp=000A", r); end
    endtask

    task automatic test_rx_path();
        logic [15:0] r;
        logic [15:0] words [3];
        words[0] = 16'hA0A0; words[1] = 16'hB1B1; words[2] = 16'hC2C2;
        for (int i = 0; i < 3; i++) begin
            rx_data = words[i]; rx_valid = 1'b1;
            cyc();
        end
        rx_valid = 1'b0;
        bus_read(3'd2, r);
        checks++; if (r !== 16'h0302) begin errors++; $display("FAIL rx_count3_status got=%h exp=0302", r); end
        for (int i = 0; i < 3; i++) begin
            bus_read(3'd1, r);
            checks++; if (r !== words[i]) begin errors++; $display("FAIL rx_read[%0d] got=%h exp=%h", i, r, words[i]); end
        end
        bus_read(3'd1, r);
        checks++; if (r !== 16'h0000) begin errors++; $display("FAIL rx_underflow_read got=%h exp=0000", r); end
        bus_read(3'd2, r);
        checks++; if (r !== 16'h002A) begin errors++; $display("FAIL rxunf_status got=%h exp=002A", r); end
        bus_write(3'd3, 16'h0001, 2'b11);
    endtask

    task automatic test_back_to_back_wrap();
        logic [15:0] r;
        logic [15:0] w [20];
        for (int i = 0; i < 20; i++) w[i] = 16'($urandom);
        s_rx_data = w[0]; s_rx_valid = 1'b1;
        cyc();
        for (int i = 1; i < 20; i++) begin
            s_rx_data = w[i]; s_rx_valid = 1'b1;
            s_addr = 3'd1; s_re = 1'b1;
            cyc();
            checks++; if (s_rdata !== w[i-1]) begin errors++; $display("FAIL wrap_read[%0d] got=%h exp=%h", i - 1, s_rdata, w[i-1]); end
        end
        s_rx_valid = 1'b0; s_re = 1'b0;
        s_read(3'd2, r);
        checks++; if (r !== 16'h0102) begin errors++; $display("FAIL wrap_count_status got=%h exp=0102", r); end
        s_read(3'd1, r);
        checks++; if (r !== w[19]) begin errors++; $display("FAIL wrap_last got=%h exp=%h", r, w[19]); end
        // Flush colliding with a push.
        s_rx_data = 16'h1111; s_rx_valid = 1'b1;
        cyc(); cyc();
        s_rx_data = 16'h2222;
        s_addr = 3'd3; s_wdata = 16'h0004; s_be = 2'b11; s_we = 1'b1;
        cyc();
        s_we = 1'b0; s_rx_valid = 1'b0;
        s_read(3'd2, r);
        checks++; if (r !== 16'h000A) begin errors++; $display("FAIL flush_vs_push_status got=%h exp=000A", r); end
    endtask

    task automatic test_async_reset();
        logic [15:0] r;
        tx_ready = 1'b0;
        for (int i = 0; i < 4; i++) bus_write(3'd0, 16'h7700 + 16'(i), 2'b11);
        bus_read(3'd7, r);
        tx_ready = 1'b1;
        cyc();
        #2;
        rst = 1'b1;
        #1;
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL async_tx_valid got=%b exp=0", tx_valid); end
        checks++; if (bus_rdata !== 16'h0000) begin errors++; $display("FAIL async_rdata got=%h exp=0000", bus_rdata); end
        checks++; if (rx_ready !== 1'b0) begin errors++; $display("FAIL async_rx_ready got=%b exp=0", rx_ready); end
        tx_ready = 1'b0;
        cyc();
        rst = 1'b0;
    endtask

    // Randomized run against a queue model: sizes decide full/empty, the
    // queue head is the next word, and flags follow the register rules.
    task automatic test_random();
        logic [15:0] mtx[$];
        logic [15:0] mrx[$];
        logic        movf, munf, mpw;
        logic [15:0] mrdata, status, rd;
        int          depth, ts, rs, r;
        logic        clr, tfl, rfl, tpush, tpop, rpush, rpop;
        depth = 16;
        movf = 0; munf = 0; mpw = 0; mrdata = 16'h0000;
        rst = 1'b1; cyc(); rst = 1'b0;
        for (int c = 0; c < 600; c++) begin
            bus_we = 1'($urandom_range(0, 1));
            bus_re = 1'($urandom_range(0, 1));
            r = $urandom_range(0, 15);
            if (r < 6)       bus_addr = 3'd0;
            else if (r < 9)  bus_addr = 3'd1;
            else if (r < 11) bus_addr = 3'd2;
            else if (r < 12) bus_addr = 3'd3;
            else if (r < 13) bus_addr = 3'd7;
            else             bus_addr = 3'($urandom_range(4, 6));
            bus_wdata = 16'($urandom);
            if (bus_addr == 3'd3 && $urandom_range(0, 3) != 0) bus_wdata[2:1] = 2'b00;
            bus_be = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(0, 2)) : 2'b11;
            tx_ready = ((c / 100) % 2 == 0) ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 4) != 0);
            rx_valid = ((c / 100) % 2 == 1) ? ($urandom_range(0, 4) != 0) : ($urandom_range(0, 4) == 0);
            rx_data = 16'($urandom);

            ts = mtx.size(); rs = mrx.size();
            status = {8'(rs), 1'b0, mpw, munf, movf, rs == 0, rs == depth, ts == 0, ts == depth};
            rd = 16'h0000;
            if (bus_addr == 3'd1 && rs > 0) rd = mrx[0];
            else if (bus_addr == 3'd2) rd = status;
            else if (bus_addr == 3'd3) rd = 16'(ts);
            else if (bus_addr == 3'd7) rd = 16'hF1F0;
            if (bus_re) mrdata = rd;
            clr = bus_we && bus_addr == 3'd3 && bus_wdata[0];
            tfl = bus_we && bus_addr == 3'd3 && bus_wdata[1];
            rfl = bus_we && bus_addr == 3'd3 && bus_wdata[2];
            tpush = bus_we && bus_addr == 3'd0 && bus_be == 2'b11 && ts < depth;
            tpop  = tx_ready && ts > 0;
            rpush = rx_valid && rs < depth;
            rpop  = bus_re && bus_addr == 3'd1 && rs > 0;
            movf = (movf && !clr) || (bus_we && bus_addr == 3'd0 && ts == depth);
            mpw  = (mpw && !clr) || (bus_we && bus_addr == 3'd0 && bus_be != 2'b11);
            munf = (munf && !clr) || (bus_re && bus_addr == 3'd1 && rs == 0);
            if (tpop) void'(mtx.pop_front());
            if (tpush) mtx.push_back(bus_wdata);
            if (tfl) mtx.delete();
            if (rpop) void'(mrx.pop_front());
            if (rpush) mrx.push_back(rx_data);
            if (rfl) mrx.delete();

            cyc();
            checks++; if (bus_rdata !== mrdata) begin errors++; $display("FAIL rand_rdata c=%0d got=%h exp=%h", c, bus_rdata, mrdata); end
            checks++; if (tx_valid !== (mtx.size() > 0)) begin errors++; $display("FAIL rand_tx_valid c=%0d got=%b exp=%b", c, tx_valid, mtx.size() > 0); end
            checks++; if (tx_data !== ((mtx.size() > 0) ? mtx[0] : 16'h0000)) begin errors++; $display("FAIL rand_tx_data c=%0d got=%h", c, tx_data); end
            checks++; if (rx_ready !== (mrx.size() < depth)) begin errors++; $display("FAIL rand_rx_ready c=%0d got=%b exp=%b", c, rx_ready, mrx.size() < depth); end
        end
        bus_we = 1'b0; bus_re = 1'b0; tx_ready = 1'b0; rx_valid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout reached got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_tx_fill();
        test_partial_write();
        test_rx_path();
        test_back_to_back_wrap();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
